// File: rtl/life_board_engine_if.sv
// Bundle between the two-phase control FSM and the cell-array datapath.
// The FSM drives the control strobes and the cell index. The engine returns
// the board, the generation count and the sticky status flags.
interface life_board_engine_if #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int CW   = 9
);
    logic                   load_en;
    logic                   read_en;
    logic                   write_en;
    logic                   writeout;
    logic                   restart;
    logic [CW-1:0]          count;
    logic                   din;
    logic [ROWS*COLS-1:0]   board_out;
    logic [CW-1:0]          gen_count;
    logic                   lose_sig;
    logic                   commit_err;

    // FSM side
    modport master (
        output load_en, read_en, write_en, writeout, restart, count, din,
        input  board_out, gen_count, lose_sig, commit_err
    );

    // Engine side
    modport slave (
        input  load_en, read_en, write_en, writeout, restart, count, din,
        output board_out, gen_count, lose_sig, commit_err
    );
endinterface

// File: rtl/life_board_engine.sv
// Game of Life cell-array datapath.
// Holds the current board, loads a pattern one cell per cycle, computes the
// next generation one cell per cycle into a shadow board, and commits the
// shadow board on writeout once every cell has been computed. Flags a lost
// game when a commit leaves the board empty or unchanged.
module life_board_engine #(
    parameter int ROWS = 4,
    parameter int COLS = 4,
    parameter int CW   = 9
) (
    input  logic               clka,
    input  logic               reset,
    life_board_engine_if.slave bus
);

    localparam int N    = ROWS * COLS;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam int PC   = COLS + 2;
    localparam int PR   = ROWS + 2;
    localparam int PW   = PR * PC;

    logic [N-1:0]    r_cur;
    logic [N-1:0]    r_nxt;
    logic [N-1:0]    r_done;
    logic [CW-1:0]   r_gen_count;
    logic            r_lose_sig;
    logic            r_commit_err;

    logic            w_in_range;
    logic [IDXW-1:0] w_idx;
    logic            w_load;
    logic            w_read;
    logic            w_all_done;
    logic [PW-1:0]   w_pad;
    logic [N-1:0]    w_life_all;

    // Decoded requests. Load outranks read, so read also requires !load_en.
    assign w_in_range = ({1'b0, bus.count} < (CW+1)'(N));
    assign w_idx      = bus.count[IDXW-1:0];
    assign w_load     = bus.load_en & bus.write_en;
    assign w_read     = bus.read_en & bus.write_en & ~bus.load_en;
    assign w_all_done = &r_done;

    // The board is framed by a one-cell ring of dead cells so every cell can
    // use the same eight neighbour offsets without edge special cases.
    for (genvar gpr = 0; gpr < PR; gpr++) begin : g_pad_row
        for (genvar gpc = 0; gpc < PC; gpc++) begin : g_pad_col
            if (gpr == 0 || gpr == PR - 1 || gpc == 0 || gpc == PC - 1) begin : g_edge
                assign w_pad[gpr*PC + gpc] = 1'b0;
            end else begin : g_inner
                assign w_pad[gpr*PC + gpc] = r_cur[(gpr-1)*COLS + (gpc-1)];
            end
        end
    end

    // Next-state value for every cell, computed in parallel from the
    // current board; the addressed cell is picked off during a read.
    for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
        for (genvar gc = 0; gc < COLS; gc++) begin : g_col
            localparam int P = (gr + 1) * PC + (gc + 1);
            logic [3:0] w_sum;

            assign w_sum = 4'(w_pad[P-PC-1]) + 4'(w_pad[P-PC]) + 4'(w_pad[P-PC+1])
                         + 4'(w_pad[P-1])                       + 4'(w_pad[P+1])
                         + 4'(w_pad[P+PC-1]) + 4'(w_pad[P+PC]) + 4'(w_pad[P+PC+1]);

            assign w_life_all[gr*COLS + gc] = r_cur[gr*COLS + gc]
                                            ? ((w_sum == 4'd2) || (w_sum == 4'd3))
                                            : (w_sum == 4'd3);
        end
    end

    // Board, shadow board, completion mask and status registers.
    // Priority: reset > restart > load > read > writeout.
    always_ff @(posedge clka) begin
        if (reset || bus.restart) begin
            r_cur        <= '0;
            r_nxt        <= '0;
            r_done       <= '0;
            r_gen_count  <= '0;
            r_lose_sig   <= 1'b0;
            r_commit_err <= 1'b0;
        end else if (w_load) begin
            // A new pattern invalidates any partially computed generation.
            if (w_in_range) begin
                r_cur[w_idx] <= bus.din;
            end
            r_nxt  <= '0;
            r_done <= '0;
        end else if (w_read) begin
            if (w_in_range) begin
                r_nxt[w_idx]  <= w_life_all[w_idx];
                r_done[w_idx] <= 1'b1;
            end
        end else if (bus.writeout) begin
            if (w_all_done) begin
                r_cur      <= r_nxt;
                r_done     <= '0;
                r_lose_sig <= r_lose_sig | (r_nxt == '0) | (r_nxt == r_cur);
                if (r_gen_count != {CW{1'b1}}) begin
                    r_gen_count <= r_gen_count + 1'b1;
                end
            end else begin
                // Incomplete shadow board: keep the computed cells so the
                // remaining reads can still finish this generation.
                r_commit_err <= 1'b1;
            end
        end
    end

    assign bus.board_out  = r_cur;
    assign bus.gen_count  = r_gen_count;
    assign bus.lose_sig   = r_lose_sig;
    assign bus.commit_err = r_commit_err;

endmodule
